hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: control-flow redirects, load-use bubbles, fetch back-pressure and operand forwarding.
// Define HAZARD_PERF_CNT_EN to build the redirect/stall performance counters; otherwise both read as zero.
module hazard_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             BranchE,
  input  logic             ZeroE,
  input  logic             JumpE,
  input  logic             JALRE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic             ResultSrcE0,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             imem_ready,
  output logic [1:0]       PCSel,
  output logic [WIDTH-1:0] RedirPC,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Busy,
  output logic [31:0]      RedirCnt,
  output logic [31:0]      StallCnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] redir_r;
  logic             taken_s;
  logic             jalr_s;
  logic             lu_s;
  logic [1:0]       tsel_s;
  logic [WIDTH-1:0] tgt_s;

  // Memory stage wins over writeback so the youngest producer is forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs)) begin
      return 2'b10;
    end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign taken_s = JumpE | (BranchE & ZeroE);
  assign jalr_s  = JumpE & JALRE;
  assign tsel_s  = jalr_s ? 2'b10 : 2'b01;
  assign tgt_s   = jalr_s ? ALUResultE : PCTargetE;
  assign lu_s    = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  assign RedirPC   = redir_r;
  assign Busy      = !rst && (state_r != RUN);

  // Next-PC select and stall/flush decode; a taken transfer overrides every state.
  always_comb begin
    PCSel  = 2'b00;
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      PCSel = 2'b00;
    end else if (taken_s) begin
      PCSel  = tsel_s;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (lu_s || !imem_ready) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else begin
            PCSel = 2'b00;
          end
        end
        LU_STALL: PCSel = 2'b00;
        REDIR_PEND: begin
          PCSel  = 2'b11;
          FlushD = 1'b1;
        end
        default: PCSel = 2'b00;
      endcase
    end
  end

  // Control FSM and pending-redirect target latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      redir_r <= '0;
    end else if (taken_s) begin
      if (imem_ready) begin
        state_r <= RUN;
      end else begin
        state_r <= REDIR_PEND;
        redir_r <= tgt_s;
      end
    end else begin
      case (state_r)
        RUN:        state_r <= lu_s ? LU_STALL : RUN;
        LU_STALL:   state_r <= RUN;
        REDIR_PEND: state_r <= imem_ready ? RUN : REDIR_PEND;
        default:    state_r <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] redir_cnt_r;
  logic [31:0] stall_cnt_r;

  // Free-running event counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      redir_cnt_r <= redir_cnt_r + {31'd0, taken_s};
      stall_cnt_r <= stall_cnt_r + {31'd0, StallF};
    end
  end

  assign RedirCnt = redir_cnt_r;
  assign StallCnt = stall_cnt_r;
`else
  assign RedirCnt = 32'd0;
  assign StallCnt = 32'd0;
`endif

endmodule
